mips_fetch_unit: RTL and testbench
==================================

# mips_fetch_unit

Instruction-fetch stage that sits directly upstream of the opcode decoder (`Control_unit`) in the MIPS processor. It holds the PC and fetches one instruction per step over a request/acknowledge instruction-memory port. It presents the latched instruction and its opcode field `Inst_A` to the decoder. It then selects the next PC from that step's Jump, Branch/Zero and Exception results, and records the EPC on exceptions.

## Interface

- `RESET_PC`, 32'h0000_0000: PC loaded on reset; bits [1:0] must be 0.
- `EXC_VECTOR`, 32'h0000_0080: PC loaded on an exception; bits [1:0] must be 0.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `imem_req`  out  1  fetch request to instruction memory.
- `imem_addr`  out  32  fetch address; equals `PC`.
- `imem_ack`  in  1  memory has valid data on `imem_rdata`.
- `imem_rdata`  in  32  instruction word.
- `Instr`  out  32  latched instruction.
- `Inst_A`  out  6  `Instr[31:26]`, goes to the decoder.
- `Instr_valid`  out  1  the datapath executes `Instr` this cycle.
- `PC`  out  32  address of `Instr`.
- `PC_plus4`  out  32  `PC + 4`, modulo 2^32.
- `EPC`  out  32  PC of the most recent excepting instruction.
- `Jump`, `Branch`, `Exception`  in  1 each  decoder outputs for the current `Instr`.
- `Zero`  in  1  ALU zero flag for the current `Instr`.
- `hold`  in  1  datapath stall request.

## Operation

- FSM states: IDLE, FETCH, EXEC.
- **IDLE**
  - Entered on reset.
  - Moves unconditionally to FETCH on the next edge.
- **FETCH**
  - `imem_req`=1, `imem_addr`=`PC`.
  - Both outputs stay stable until `imem_ack`.
  - On an edge with `imem_ack`=1: `Instr`←`imem_rdata`, go to EXEC.
- **EXEC**
  - `Instr_valid`=1, `imem_req`=0.
  - With `hold`=1: stay in EXEC and change no state.
  - With `hold`=0: update `PC` and return to FETCH.
- Next-PC priority when leaving EXEC (first match wins):
  - `Exception`=1: `EPC`←`PC`, `PC`←`EXC_VECTOR`.
  - `Jump`=1: `PC`←{`PC_plus4[31:28]`, `Instr[25:0]`, 2'b00}.
  - `Branch`=1 and `Zero`=1: `PC`←`PC_plus4` + (sign-extended `Instr[15:0]` << 2).
  - Otherwise: `PC`←`PC_plus4`.
- Arithmetic rules:
  - All adds are 32-bit and wrap modulo 2^32 with no overflow flag.
  - Target bits [1:0] are always 0.
- Control inputs (`Jump`, `Branch`, `Zero`, `Exception`) are sampled only on the EXEC exit edge and ignored in IDLE and FETCH. An X on them outside EXEC is legal.
- `imem_ack` is ignored in IDLE and EXEC.
- `EPC` changes only on an exception exit.

## Timing

- Reset values (asynchronous, immediate on `rst_n` low):
  - state = IDLE, `PC` = `RESET_PC`, `imem_addr` = `RESET_PC`.
  - `imem_req` = 0, `Instr` = 0, `Inst_A` = 0, `Instr_valid` = 0, `EPC` = 0.
- Because `Inst_A`=0 decodes as R-type, consumers must qualify it with `Instr_valid`.
- Zero-wait memory (ack in the first FETCH cycle): 2 cycles per instruction (FETCH, EXEC).
- After reset release: the first `imem_req` comes 1 cycle later; the first `Instr_valid` comes 2 cycles later.
- Each memory wait cycle adds exactly 1 cycle.
- `Instr_valid` lasts 1 cycle, plus 1 cycle for each cycle `hold` is asserted.
- `PC` and `Instr` stay constant for the whole EXEC period.
- `rst_n` asserted mid-FETCH or mid-EXEC aborts the operation. Any late `imem_ack` is then ignored because the FSM is in IDLE.
- `Exception`, `Jump` and `Branch`+`Zero` together: exception wins, and only `EPC`/`PC` change per that rule.

## Structure

- Shared package `mips_pkg` holds:
  - fetch state enum {IDLE, FETCH, EXEC};
  - opcode field position constants (31:26, 25:0, 15:0);
  - default `RESET_PC` and `EXC_VECTOR` values.
- Sub-module `mips_next_pc`: purely combinational priority mux and adders.
  - Inputs: `PC`, `Instr`, `Jump`, `Branch`, `Zero`, `Exception`.
  - Outputs: next PC and `PC_plus4`.
- The top level holds the FSM, the `PC`/`Instr`/`EPC` registers, and the memory handshake.

## Test plan

- **Reset and first fetch:** release `rst_n`, memory acks in the first cycle with 32'h0000_0020 (add) → `imem_req`/`imem_addr`=0 one cycle after release, `Instr_valid` the next cycle, `Inst_A`=0, next `imem_addr`=0x4.
- **Wait states:** memory acks after 3 wait cycles → `imem_addr` stable throughout, 5 cycles per instruction.
- **Taken branch:**
  - At `PC`=0x10 with `Instr`=32'h1000_FFFE, `Branch`=1, `Zero`=1 → next `PC`=0x0C.
  - Same with `Zero`=0 → next `PC`=0x14.
- **Jump:** at `PC`=0x1000_0040 with `Instr`=32'h0800_0100 and `Jump`=1 → next `PC`=0x1000_0400.
- **Exception priority:** at `PC`=0x24 with `Exception`=1, `Jump`=1 → `EPC`=0x24, next `PC`=0x80.
- **Hold and reset abort:**
  - `hold`=1 for 3 cycles → `Instr_valid` high for 4 cycles, `PC` unchanged.
  - `rst_n` pulsed low mid-FETCH, then a stray `imem_ack` → all outputs return to reset values, and the stray ack is ignored.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS fetch stage: fetch FSM states,
// instruction field positions and default reset/exception addresses.
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2
  } fetch_state_e;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 26;
  localparam int TGT_MSB = 25;
  localparam int TGT_LSB = 0;
  localparam int IMM_MSB = 15;
  localparam int IMM_LSB = 0;

  localparam logic [31:0] RESET_PC_DEFAULT   = 32'h0000_0000;
  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'h0000_0080;

endpackage

// File: rtl/mips_next_pc.sv
// Combinational next-PC selection: exception > jump > taken branch > PC+4.
module mips_next_pc
  import mips_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT
) (
  input  logic [31:0]      pc,
  // Only the jump-target field is needed; the branch immediate lies inside it.
  input  logic [TGT_MSB:0] instr,
  input  logic             jump,
  input  logic             branch,
  input  logic             zero,
  input  logic             exception,
  output logic [31:0]      next_pc,
  output logic [31:0]      pc_plus4
);

  logic [31:0] branch_off;
  logic [31:0] branch_tgt;
  logic [31:0] jump_tgt;

  always_comb begin
    pc_plus4   = pc + 32'd4;
    branch_off = {{14{instr[IMM_MSB]}}, instr[IMM_MSB:IMM_LSB], 2'b00};
    branch_tgt = pc_plus4 + branch_off;
    jump_tgt   = {pc_plus4[31:28], instr[TGT_MSB:TGT_LSB], 2'b00};

    if (exception)           next_pc = EXC_VECTOR;
    else if (jump)           next_pc = jump_tgt;
    else if (branch && zero) next_pc = branch_tgt;
    else                     next_pc = pc_plus4;
  end

endmodule

// File: rtl/mips_fetch_unit.sv
// Instruction fetch stage: holds PC/EPC, fetches one word per step over a
// req/ack memory port and hands the latched instruction to the decoder.
//
//   state | meaning
//   IDLE  | just out of reset, one cycle before the first request
//   FETCH | imem_req high at PC, waiting for imem_ack
//   EXEC  | Instr valid for the datapath; leaves when hold is low
module mips_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instr,
  output logic [5:0]  Inst_A,
  output logic        Instr_valid,
  output logic [31:0] PC,
  output logic [31:0] PC_plus4,
  output logic [31:0] EPC,
  input  logic        Jump,
  input  logic        Branch,
  input  logic        Exception,
  input  logic        Zero,
  input  logic        hold
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  epc_q, epc_d;
  logic         imem_req_q, imem_req_d;
  logic         instr_valid_q, instr_valid_d;
  logic [31:0]  next_pc;

  mips_next_pc #(
    .EXC_VECTOR(EXC_VECTOR)
  ) u_next_pc (
    .pc        (pc_q),
    .instr     (instr_q[TGT_MSB:0]),
    .jump      (Jump),
    .branch    (Branch),
    .zero      (Zero),
    .exception (Exception),
    .next_pc   (next_pc),
    .pc_plus4  (PC_plus4)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    epc_d   = epc_q;
    unique case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = EXEC;
        end
      end
      EXEC: begin
        // Control inputs are only trusted here, on the exit edge.
        if (!hold) begin
          pc_d    = next_pc;
          if (Exception) epc_d = pc_q;
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
    imem_req_d    = (state_d == FETCH);
    instr_valid_d = (state_d == EXEC);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      instr_q       <= '0;
      epc_q         <= '0;
      imem_req_q    <= 1'b0;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      epc_q         <= epc_d;
      imem_req_q    <= imem_req_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = pc_q;
  assign PC          = pc_q;
  assign Instr       = instr_q;
  assign Inst_A      = instr_q[OPC_MSB:OPC_LSB];
  assign Instr_valid = instr_valid_q;
  assign EPC         = epc_q;

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Directed self-checking bench for mips_fetch_unit.
module tb_mips_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] Instr;
  logic [5:0]  Inst_A;
  logic        Instr_valid;
  logic [31:0] PC;
  logic [31:0] PC_plus4;
  logic [31:0] EPC;
  logic        Jump, Branch, Exception, Zero, hold;

  int tests = 0;
  int fails = 0;

  mips_fetch_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .Instr       (Instr),
    .Inst_A      (Inst_A),
    .Instr_valid (Instr_valid),
    .PC          (PC),
    .PC_plus4    (PC_plus4),
    .EPC         (EPC),
    .Jump        (Jump),
    .Branch      (Branch),
    .Exception   (Exception),
    .Zero        (Zero),
    .hold        (hold)
  );

  always #5 clk = ~clk;

  // Stimulus only: from a FETCH negedge, ack one word, then leave EXEC with
  // the given controls. Returns at the next FETCH negedge.
  task automatic step_instr(input logic [31:0] word, input logic j, input logic b,
                            input logic z, input logic e);
    imem_ack = 1'b1; imem_rdata = word;
    @(negedge clk);
    imem_ack = 1'b0;
    Jump = j; Branch = b; Zero = z; Exception = e; hold = 1'b0;
    @(negedge clk);
    Jump = 1'b0; Branch = 1'b0; Zero = 1'b0; Exception = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
    Jump = 1'b0; Branch = 1'b0; Zero = 1'b0; Exception = 1'b0; hold = 1'b0;
    repeat (2) @(negedge clk);
    tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL rst_req got %b exp 0", imem_req); end
    tests++; if (imem_addr !== 32'h0) begin fails++; $display("FAIL rst_addr got %h exp 0", imem_addr); end
    tests++; if (PC !== 32'h0) begin fails++; $display("FAIL rst_pc got %h exp 0", PC); end
    tests++; if (Instr !== 32'h0 || Inst_A !== 6'h0) begin fails++; $display("FAIL rst_instr got %h/%h exp 0", Instr, Inst_A); end
    tests++; if (Instr_valid !== 1'b0) begin fails++; $display("FAIL rst_valid got %b exp 0", Instr_valid); end
    tests++; if (EPC !== 32'h0) begin fails++; $display("FAIL rst_epc got %h exp 0", EPC); end
    rst_n = 1'b1;
    @(negedge clk);
    tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || Instr_valid !== 1'b0)
      begin fails++; $display("FAIL first_req got req=%b addr=%h v=%b exp 1/0/0", imem_req, imem_addr, Instr_valid); end
    imem_ack = 1'b1; imem_rdata = 32'h0000_0020;
    @(negedge clk);
    imem_ack = 1'b0;
    tests++; if (Instr_valid !== 1'b1 || imem_req !== 1'b0)
      begin fails++; $display("FAIL first_valid got v=%b req=%b exp 1/0", Instr_valid, imem_req); end
    tests++; if (Instr !== 32'h0000_0020 || Inst_A !== 6'h0)
      begin fails++; $display("FAIL first_instr got %h/%h exp 00000020/00", Instr, Inst_A); end
    tests++; if (PC_plus4 !== 32'h4) begin fails++; $display("FAIL first_pc4 got %h exp 4", PC_plus4); end
    @(negedge clk);
    tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h4 || Instr_valid !== 1'b0)
      begin fails++; $display("FAIL second_fetch got req=%b addr=%h v=%b exp 1/4/0", imem_req, imem_addr, Instr_valid); end
  endtask

  task automatic test_wait_states();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h4 || Instr_valid !== 1'b0)
        begin fails++; $display("FAIL wait_stable[%0d] got req=%b addr=%h v=%b exp 1/4/0", i, imem_req, imem_addr, Instr_valid); end
    end
    imem_ack = 1'b1; imem_rdata = 32'h0000_0000;
    @(negedge clk);
    imem_ack = 1'b0;
    tests++; if (Instr_valid !== 1'b1 || PC !== 32'h4)
      begin fails++; $display("FAIL wait_exec got v=%b pc=%h exp 1/4", Instr_valid, PC); end
    @(negedge clk);
    tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h8 || Instr_valid !== 1'b0)
      begin fails++; $display("FAIL wait_5cyc got req=%b addr=%h v=%b exp 1/8/0", imem_req, imem_addr, Instr_valid); end
  endtask

  task automatic test_branch();
    step_instr(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    step_instr(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    tests++; if (PC !== 32'h10) begin fails++; $display("FAIL seq_pc got %h exp 10", PC); end
    step_instr(32'h1000_FFFE, 1'b0, 1'b1, 1'b1, 1'b0);
    tests++; if (PC !== 32'h0C || imem_addr !== 32'h0C)
      begin fails++; $display("FAIL br_taken got pc=%h addr=%h exp 0c", PC, imem_addr); end
    step_instr(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    step_instr(32'h1000_FFFE, 1'b0, 1'b1, 1'b0, 1'b0);
    tests++; if (PC !== 32'h14) begin fails++; $display("FAIL br_not_taken got %h exp 14", PC); end
  endtask

  task automatic test_exception();
    repeat (4) step_instr(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    tests++; if (PC !== 32'h24 || EPC !== 32'h0)
      begin fails++; $display("FAIL pre_exc got pc=%h epc=%h exp 24/0", PC, EPC); end
    step_instr(32'h0800_0100, 1'b1, 1'b1, 1'b1, 1'b1);
    tests++; if (EPC !== 32'h24) begin fails++; $display("FAIL exc_epc got %h exp 24", EPC); end
    tests++; if (PC !== 32'h80) begin fails++; $display("FAIL exc_pc got %h exp 80", PC); end
    step_instr(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    tests++; if (PC !== 32'h84 || EPC !== 32'h24)
      begin fails++; $display("FAIL post_exc got pc=%h epc=%h exp 84/24", PC, EPC); end
  endtask

  task automatic test_hold();
    int vcnt = 0;
    imem_ack = 1'b1; imem_rdata = 32'h8C42_0004;
    @(negedge clk);
    imem_ack = 1'b0;
    if (Instr_valid === 1'b1) vcnt++;
    hold = 1'b1; Jump = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (Instr_valid === 1'b1) vcnt++;
      tests++; if (PC !== 32'h84 || Instr !== 32'h8C42_0004)
        begin fails++; $display("FAIL hold_stable[%0d] got pc=%h instr=%h exp 84/8c420004", i, PC, Instr); end
    end
    hold = 1'b0; Jump = 1'b0;
    @(negedge clk);
    if (Instr_valid === 1'b1) vcnt++;
    tests++; if (vcnt != 4) begin fails++; $display("FAIL hold_valid_len got %0d exp 4", vcnt); end
    tests++; if (PC !== 32'h88 || imem_req !== 1'b1)
      begin fails++; $display("FAIL hold_exit got pc=%h req=%b exp 88/1", PC, imem_req); end
  endtask

  task automatic test_reset_abort();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    tests++; if (imem_req !== 1'b0 || imem_addr !== 32'h0 || PC !== 32'h0)
      begin fails++; $display("FAIL abort_pc got req=%b addr=%h pc=%h exp 0", imem_req, imem_addr, PC); end
    tests++; if (EPC !== 32'h0 || Instr !== 32'h0 || Instr_valid !== 1'b0)
      begin fails++; $display("FAIL abort_regs got epc=%h instr=%h v=%b exp 0", EPC, Instr, Instr_valid); end
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
    tests++; if (Instr !== 32'h0 || Instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0)
      begin fails++; $display("FAIL stray_ack got instr=%h v=%b req=%b addr=%h exp 0/0/1/0", Instr, Instr_valid, imem_req, imem_addr); end
    @(negedge clk);
    tests++; if (Instr_valid !== 1'b0 || imem_req !== 1'b1)
      begin fails++; $display("FAIL stray_ack2 got v=%b req=%b exp 0/1", Instr_valid, imem_req); end
  endtask

  task automatic test_jump();
    // 2048 branches of +0x20000 each walk the PC up to 0x1000_0000.
    for (int i = 0; i < 2048; i++) step_instr(32'h1000_7FFF, 1'b0, 1'b1, 1'b1, 1'b0);
    tests++; if (PC !== 32'h1000_0000) begin fails++; $display("FAIL br_walk got %h exp 10000000", PC); end
    step_instr(32'h1000_000F, 1'b0, 1'b1, 1'b1, 1'b0);
    tests++; if (PC !== 32'h1000_0040) begin fails++; $display("FAIL br_small got %h exp 10000040", PC); end
    step_instr(32'h0800_0100, 1'b1, 1'b0, 1'b0, 1'b0);
    tests++; if (PC !== 32'h1000_0400 || PC_plus4 !== 32'h1000_0404)
      begin fails++; $display("FAIL jump got pc=%h pc4=%h exp 10000400/10000404", PC, PC_plus4); end
  endtask

  initial begin
    test_reset();
    test_wait_states();
    test_branch();
    test_exception();
    test_hold();
    test_reset_abort();
    test_jump();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
